reg_cmd_controller: RTL and testbench
=====================================

// Module: reg_cmd_controller
// PURPOSE
//  Command-side initiator for the register file: parses command frames arriving as bytes from the UART receiver,
//  issues single-cycle write/read strobes to the register file, returns read data to the UART transmitter via valid/ready.
//  Sits between uart_rx/uart_tx and register_file in the system top.
// PARAMETERS
//  DATA_WIDTH           8     byte/register width
//  REGISTER_FILE_DEPTH  16    register count; ADDR_W = $clog2(REGISTER_FILE_DEPTH)
//  FRAME_TIMEOUT        1024  max idle cycles between bytes of one frame before abort
//  READ_TIMEOUT         4     max cycles to wait for read_data_valid after read strobe
// PORTS
//  clk              in   1           system clock
//  reset            in   1           asynchronous, active-low reset
//  rx_data          in   DATA_WIDTH  received byte
//  rx_data_valid    in   1           1-cycle pulse, rx_data valid
//  address          out  ADDR_W      register file address
//  write_enable     out  1           1-cycle write strobe
//  write_data       out  DATA_WIDTH  write data
//  read_enable      out  1           1-cycle read strobe
//  read_data        in   DATA_WIDTH  register file read data
//  read_data_valid  in   1           read data valid (1 cycle after read_enable)
//  tx_data          out  DATA_WIDTH  byte to transmitter
//  tx_valid         out  1           tx_data valid; held until accepted
//  tx_ready         in   1           transmitter accepts when tx_valid & tx_ready at posedge
//  busy             out  1           high in any state other than IDLE
//  frame_error      out  1           1-cycle pulse on timeout abort
// BEHAVIOUR
//  Frames: WRITE = 0xAA, addr, data; READ = 0xBB, addr. Addr byte truncated to low ADDR_W bits.
//  All outputs registered. Reset value of every output 0; state IDLE; timeout counter 0.
//  States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
//   IDLE:    byte 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte dropped, stay IDLE, no error.
//   WR_ADDR: byte -> latch address, -> WR_DATA.
//   WR_DATA: byte -> write_data<=byte, write_enable<=1 for exactly 1 cycle (cycle after byte edge), -> IDLE.
//   RD_ADDR: byte -> latch address, read_enable<=1 for exactly 1 cycle, -> RD_WAIT.
//   RD_WAIT: read_data_valid=1 -> tx_data<=read_data, tx_valid<=1, -> TX_SEND.
//   TX_SEND: tx_valid held, tx_data stable; tx_valid&tx_ready at edge -> tx_valid<=0, -> IDLE.
//  Latency: write strobe 1 cycle after data byte; tx_valid 2 cycles after read strobe (regfile latency 1).
//  Timeout counter clears on state entry and on each accepted byte; increments otherwise in WR_ADDR/WR_DATA/RD_ADDR
//   (limit FRAME_TIMEOUT) and RD_WAIT (limit READ_TIMEOUT). Reaching limit-1 -> frame_error pulse, -> IDLE, no strobes.
//  rx bytes in RD_WAIT/TX_SEND dropped silently; frame in progress unaffected.
//  write_enable and read_enable never high in same cycle. address held stable until next frame latches.
//  Back-to-back frames: new 0xAA/0xBB accepted in IDLE on the cycle a write strobe is out.
//  Reset mid-frame: immediate return to IDLE, all outputs 0, partial frame discarded.
// STRUCTURE
//  Package reg_cmd_pkg: WRITE_CMD=8'hAA, READ_CMD=8'hBB, state enum/localparams.
//  Sub-module timeout_counter (clear, enable, limit input, expired output); one instance, width $clog2(FRAME_TIMEOUT).
//  FSM + output registers in this module.
// TESTING
//  Bytes AA,05,3C -> one write_enable pulse, address=5, write_data=0x3C; regfile reg5 reads 0x3C.
//  Bytes BB,05 (reg5=0x3C), tx_ready=1 -> read_enable 1 cycle, tx_valid 2 cycles later, tx_data=0x3C, 1-cycle handshake.
//  Read with tx_ready low 20 cycles -> tx_valid/tx_data held 20 cycles, rx byte 0x11 mid-wait dropped, then IDLE.
//  Bytes AA,02 then silence 1024 cycles -> frame_error pulse, no write_enable, next AA,02,07 writes reg2=0x07.
//  Byte 0x55 then BB,13 (depth 16) -> 0x55 ignored, address=3 (truncated), no error.
//  Reset asserted after AA,04 -> all outputs 0, IDLE; following 03 byte ignored (no write).

Source files
------------

// File: rtl/reg_cmd_pkg.sv
// Shared command codes and FSM state encoding for the register command controller.
package reg_cmd_pkg;

  localparam logic [7:0] WRITE_CMD = 8'hAA;
  localparam logic [7:0] READ_CMD  = 8'hBB;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  // States in which the idle/response timeout is running.
  function automatic logic is_timed_state(input state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) || (s == RD_WAIT);
  endfunction

endpackage

// File: rtl/reg_cmd_controller_timeout_counter.sv
// Cycle counter with clear/enable; expired is high while the count equals the terminal value in limit.
module timeout_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == limit);

endmodule

// File: rtl/reg_cmd_controller.sv
// Byte-frame command parser: turns UART write/read frames into register file strobes
// and returns read data to the transmitter over a valid/ready handshake.
module reg_cmd_controller
  import reg_cmd_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int FRAME_TIMEOUT       = 1024,
  parameter int READ_TIMEOUT        = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [DATA_WIDTH-1:0]                  rx_data,
  input  logic                                   rx_data_valid,
  output logic [$clog2(REGISTER_FILE_DEPTH)-1:0] address,
  output logic                                   write_enable,
  output logic [DATA_WIDTH-1:0]                  write_data,
  output logic                                   read_enable,
  input  logic [DATA_WIDTH-1:0]                  read_data,
  input  logic                                   read_data_valid,
  output logic [DATA_WIDTH-1:0]                  tx_data,
  output logic                                   tx_valid,
  input  logic                                   tx_ready,
  output logic                                   busy,
  output logic                                   frame_error
);

  localparam int ADDR_W = $clog2(REGISTER_FILE_DEPTH);
  localparam int CNT_W  = $clog2(FRAME_TIMEOUT);

  state_t           state;
  logic             timed;
  logic             cnt_clear;
  logic             expired;
  logic [CNT_W-1:0] cnt_limit;

  // Bytes in RD_WAIT are ignored, so they must not restart the response timeout.
  assign timed     = is_timed_state(state);
  assign cnt_clear = !timed || (rx_data_valid && (state != RD_WAIT));
  assign cnt_limit = (state == RD_WAIT) ? CNT_W'(READ_TIMEOUT - 1) : CNT_W'(FRAME_TIMEOUT - 1);

  timeout_counter #(
    .WIDTH (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (timed),
    .limit   (cnt_limit),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      address      <= '0;
      write_enable <= 1'b0;
      write_data   <= '0;
      read_enable  <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      frame_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_data_valid && (rx_data == DATA_WIDTH'(WRITE_CMD))) begin
            state <= WR_ADDR;
            busy  <= 1'b1;
          end else if (rx_data_valid && (rx_data == DATA_WIDTH'(READ_CMD))) begin
            state <= RD_ADDR;
            busy  <= 1'b1;
          end
        end
        WR_ADDR: begin
          if (rx_data_valid) begin
            address <= rx_data[ADDR_W-1:0];
            state   <= WR_DATA;
          end else if (expired) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end
        end
        WR_DATA: begin
          if (rx_data_valid) begin
            write_data   <= rx_data;
            write_enable <= 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
          end else if (expired) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (rx_data_valid) begin
            address     <= rx_data[ADDR_W-1:0];
            read_enable <= 1'b1;
            state       <= RD_WAIT;
          end else if (expired) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (read_data_valid) begin
            tx_data  <= read_data;
            tx_valid <= 1'b1;
            state    <= TX_SEND;
          end else if (expired) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end
        end
        TX_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_controller.sv
// Directed bench for reg_cmd_controller with a one-cycle-latency register file model.
module tb_reg_cmd_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic [3:0] address;
  logic       write_enable;
  logic [7:0] write_data;
  logic       read_enable;
  logic [7:0] read_data = 8'h00;
  logic       read_data_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       frame_error;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int fe_cnt = 0;
  int overlap = 0;
  logic mute = 1'b0;
  logic [7:0] regs [16];

  always #5 clk = ~clk;

  reg_cmd_controller dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_data_valid   (rx_data_valid),
    .address         (address),
    .write_enable    (write_enable),
    .write_data      (write_data),
    .read_enable     (read_enable),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .frame_error     (frame_error)
  );

  // Register file model: reset contents A0+index, writes on strobe, read data one cycle later.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'hA0 + 8'(i);
    end else if (write_enable) begin
      regs[address] <= write_data;
    end
    read_data_valid <= read_enable && !mute;
    if (read_enable) read_data <= regs[address];
    if (write_enable) we_cnt <= we_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (write_enable && read_enable) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    tick();
    rx_data       = b;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  initial begin
    int err_at;
    int held;

    // Reset state
    repeat (3) tick();
    chk("rst_outputs", {address, write_enable, write_data, read_enable, tx_data, tx_valid, busy, frame_error}, 32'h0);
    reset = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    // Write AA,05,3C
    send(8'hAA);
    chk("wr_busy", busy, 1'b1);
    send(8'h05);
    chk("wr_no_early_we", write_enable, 1'b0);
    send(8'h3C);
    chk("wr_we", write_enable, 1'b1);
    chk("wr_addr", address, 4'h5);
    chk("wr_data", write_data, 8'h3C);
    chk("wr_busy_done", busy, 1'b0);
    tick();
    chk("wr_we_one_cycle", write_enable, 1'b0);
    chk("wr_reg5", regs[5], 8'h3C);

    // Read BB,05 with tx_ready high
    tx_ready = 1'b1;
    send(8'hBB);
    send(8'h05);
    chk("rd_re", read_enable, 1'b1);
    chk("rd_addr", address, 4'h5);
    tick();
    chk("rd_re_one_cycle", read_enable, 1'b0);
    chk("rd_tx_not_yet", tx_valid, 1'b0);
    tick();
    chk("rd_tx_valid", tx_valid, 1'b1);
    chk("rd_tx_data", tx_data, 8'h3C);
    tick();
    chk("rd_handshake", tx_valid, 1'b0);
    chk("rd_idle", busy, 1'b0);

    // Write 07<=5A, then read it back with tx_ready low for 20 cycles
    send(8'hAA);
    send(8'h07);
    send(8'h5A);
    tx_ready = 1'b0;
    send(8'hBB);
    send(8'h07);
    tick();
    tick();
    chk("stall_tx_valid", tx_valid, 1'b1);
    chk("stall_tx_data", tx_data, 8'h5A);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rx_data_valid = 1'b0;
      if (tx_valid && tx_data == 8'h5A && busy) held++;
      if (i == 10) begin
        rx_data       = 8'h11;
        rx_data_valid = 1'b1;
      end
    end
    chk("stall_held_cycles", held, 20);
    tx_ready = 1'b1;
    tick();
    chk("stall_release", tx_valid, 1'b0);
    chk("stall_idle", busy, 1'b0);
    chk("stall_we_count", we_cnt, 2);

    // Frame timeout after AA,02
    send(8'hAA);
    send(8'h02);
    err_at = -1;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      if (frame_error) begin
        err_at = k;
        break;
      end
    end
    chk("timeout_cycle", err_at, 1024);
    chk("timeout_idle", busy, 1'b0);
    tick();
    chk("timeout_pulse", frame_error, 1'b0);
    chk("timeout_no_we", we_cnt, 2);
    send(8'hAA);
    send(8'h02);
    send(8'h07);
    chk("after_to_we", write_enable, 1'b1);
    tick();
    chk("after_to_reg2", regs[2], 8'h07);

    // Junk byte then read with truncated address
    send(8'h55);
    chk("junk_idle", busy, 1'b0);
    send(8'hBB);
    send(8'h13);
    chk("trunc_re", read_enable, 1'b1);
    chk("trunc_addr", address, 4'h3);
    tick();
    tick();
    chk("trunc_tx_data", tx_data, 8'hA3);
    chk("trunc_no_err", fe_cnt, 1);
    tick();

    // Read response timeout
    mute = 1'b1;
    send(8'hBB);
    send(8'h01);
    repeat (3) tick();
    chk("rd_to_not_yet", frame_error, 1'b0);
    tick();
    chk("rd_to_error", frame_error, 1'b1);
    chk("rd_to_no_tx", tx_valid, 1'b0);
    mute = 1'b0;

    // Reset mid-frame
    send(8'hAA);
    send(8'h04);
    chk("mid_addr", address, 4'h4);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_outputs", {address, write_enable, write_data, read_enable, tx_data, tx_valid, busy, frame_error}, 32'h0);
    tick();
    reset = 1'b1;
    send(8'h03);
    tick();
    chk("mid_no_we", we_cnt, 3);
    chk("mid_idle", busy, 1'b0);
    chk("no_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
